cw_frame_buffer: RTL
====================

Name: cw_frame_buffer

Overview:
- Parametrised codeword front-end for the constant-weight decoder path. Generalises the fixed 20-bit, fixed-depth buffer-plus-serializer arrangement.
- Buffers CW_W-bit codewords in an internal FIFO of configurable depth. Frames them into messages of NUM_WORDS codewords and serialises each codeword bit-by-bit to the downstream decoder core.
- Adds behaviour the previous generation lacks: valid/ready backpressure, selectable bit order, per-word last marker, sticky overflow flag and an occupancy count.

Parameters:
- CW_W, 20, codeword width in bits (>=2)
- DEPTH, 16, FIFO depth in codewords; power of two, >=2
- NUM_WORDS, 10, codewords per message (>=1)
- MSB_FIRST, 1, 1 = serialise bit CW_W-1 first; 0 = bit 0 first

Ports:
- clk  in  1  single clock, rising edge
- rst_b  in  1  synchronous active-low reset
- cw_in  in  CW_W  codeword to enqueue
- wr_en  in  1  enqueue request
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a write was dropped
- start  in  1  begin one message; sampled only in IDLE
- busy  out  1  FSM not in IDLE
- bit_out  out  1  serial data bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  downstream accepts the bit
- word_last  out  1  current bit is the last bit of its codeword
- msg_done  out  1  one-cycle pulse at message end

Behaviour:
- Reset (rst_b=0 at a clock edge) empties the FIFO and forces the FSM to IDLE.
  - count=0, empty=1, full=0, overflow=0, busy=0, bit_valid=0, bit_out=0, word_last=0, msg_done=0.
  - Reset mid-message aborts the message; no msg_done is generated.
- FIFO:
  - Write occurs when wr_en && !full, using the registered count.
  - wr_en while full: the word is dropped and overflow is set. overflow stays set until reset or an accepted start.
  - A pop in the same cycle does not make room for that cycle's write.
  - Pop occurs only from the LOAD state when !empty. There is no write-to-read bypass: a word written at edge t is poppable at edge t+1 at the earliest.
  - Simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: on start=1, go to LOAD, clear word_cnt, clear overflow. start in any other state is ignored.
  - LOAD: if !empty, pop the head into the shift register, clear bit_cnt, go to SHIFT. If empty, stay in LOAD; bit_valid stays 0 (underflow stall, no error).
  - SHIFT:
    - bit_valid=1.
    - bit_out = shift register MSB if MSB_FIRST=1, else LSB.
    - word_last=1 when bit_cnt==CW_W-1.
    - On bit_valid && bit_ready: shift by one and increment bit_cnt.
    - If the accepted bit was the last of its word: increment word_cnt, then go to DONE if word_cnt==NUM_WORDS-1, else go to LOAD.
    - With bit_ready=0: bit_out, bit_valid and word_last hold stable.
  - DONE: msg_done=1 for exactly one cycle, then go to IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Latency and throughput:
  - start accepted at edge t with a non-empty FIFO: pop at edge t+1, first bit_valid in the cycle after edge t+1.
  - One-cycle LOAD bubble between codewords.
  - CW_W+1 cycles per word with bit_ready held high.
- All outputs are driven from registered state; no combinational path from bit_ready to bit_valid.

Test Plan:
- Defaults, write 10 words 0xAAAAA..., start, bit_ready=1 -> 200 bits, pattern 1,0,1,0...; word_last on every 20th bit; msg_done pulses 211 cycles after start; busy falls the cycle after.
- MSB_FIRST=0, write 0x00001 -> bit_out=1 on the first bit, then 19 zeros; word_last on the 20th bit.
- Toggle bit_ready pseudo-randomly over a 10-word message -> bit stream identical to the bit_ready=1 run; outputs stable while bit_ready=0.
- Write 17 words with DEPTH=16, no reads -> full=1, count=16, overflow=1, word 17 lost. Then start -> overflow=0; first 16 words output in order.
- start with an empty FIFO, write a word 5 cycles later -> FSM stalls in LOAD with bit_valid=0; first bit appears 2 cycles after the write.
- Assert rst_b=0 mid-word 3 -> next cycle all outputs at reset values, count=0, no msg_done. A new start with fresh data produces the correct message.

Source files
------------

// File: rtl/cw_frame_buffer.sv
// cw_frame_buffer
// Codeword front-end for the constant-weight decoder path. Incoming CW_W-bit
// codewords are queued in a DEPTH-entry FIFO. On start, NUM_WORDS codewords
// are popped one at a time and shifted out serially with valid/ready
// handshaking.
//
// Ports
//   clk        single clock, rising edge
//   rst_b      synchronous active-low reset
//   cw_in      codeword to enqueue
//   wr_en      enqueue request (dropped when full; this sets overflow)
//   full       FIFO holds DEPTH words
//   empty      FIFO holds 0 words
//   count      FIFO occupancy
//   overflow   sticky: a write was dropped; cleared by reset or an accepted start
//   start      begin one message; only sampled in IDLE
//   busy       FSM not in IDLE
//   bit_out    serial data bit
//   bit_valid  bit_out is valid
//   bit_ready  downstream accepts the bit
//   word_last  current bit is the last bit of its codeword
//   msg_done   one-cycle pulse at message end
module cw_frame_buffer #(
    parameter int CW_W      = 20,
    parameter int DEPTH     = 16,
    parameter int NUM_WORDS = 10,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [CW_W-1:0]            cw_in,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       start,
    output logic                       busy,
    output logic                       bit_out,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic                       word_last,
    output logic                       msg_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(CW_W);
    localparam int WC_W  = $clog2(NUM_WORDS + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(CW_W - 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [CW_W-1:0]   shift_reg, shift_next;
    logic [BC_W-1:0]   bit_cnt_reg;
    logic [WC_W-1:0]   word_cnt_reg;

    logic full_int, empty_int;
    logic wr_accept, pop, start_accept, bit_take, last_bit;

    assign full_int     = (count_reg == DEPTH_C);
    assign empty_int    = (count_reg == '0);
    // full is judged on the registered count, so a same-cycle pop never
    // frees a slot for the write in that cycle.
    assign wr_accept    = wr_en && !full_int;
    assign pop          = (state_reg == LOAD) && !empty_int;
    assign start_accept = (state_reg == IDLE) && start;
    assign bit_take     = (state_reg == SHIFT) && bit_ready;
    assign last_bit     = (bit_cnt_reg == BIT_LAST);

    // The bit just sent leaves the register and a zero fills the vacated end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[CW_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shift_next = {1'b0, shift_reg[CW_W-1:1]};
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (pop) state_next = SHIFT;
            SHIFT: if (bit_take && last_bit)
                       state_next = (word_cnt_reg == WORD_LAST) ? DONE : LOAD;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only; bit_ready never reaches them.
    always_comb begin
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        word_last = 1'b0;
        msg_done  = 1'b0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = MSB_FIRST ? shift_reg[CW_W-1] : shift_reg[0];
                word_last = last_bit;
            end
            DONE:    msg_done = 1'b1;
            default: ;
        endcase
    end

    // Storage array: no reset so it maps onto block RAM. The read is
    // registered into shift_reg below.
    always_ff @(posedge clk) begin
        if (rst_b && wr_accept)
            mem[wr_ptr_reg] <= cw_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (wr_accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;

            if (wr_accept && !pop)
                count_reg <= count_reg + 1'b1;
            else if (!wr_accept && pop)
                count_reg <= count_reg - 1'b1;

            // A dropped write wins over a clearing start in the same cycle
            // so that the lost word is never silently forgotten.
            if (wr_en && full_int)
                overflow_reg <= 1'b1;
            else if (start_accept)
                overflow_reg <= 1'b0;

            if (start_accept)
                word_cnt_reg <= '0;

            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                shift_reg   <= mem[rd_ptr_reg];
                bit_cnt_reg <= '0;
            end else if (bit_take) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                if (last_bit)
                    word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    assign full     = full_int;
    assign empty    = empty_int;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule
